// File: rtl/led_nios_sysid_ext.sv
// led_nios_sysid_ext
//   System-identification and uptime slave for the Nios II Avalon-MM data bus.
//   Returns a fixed system ID, build timestamp and user build word. Also
//   provides a byte-writable scratch register and a free-running uptime
//   counter with a coherent LO/HI readout and a sticky wrap flag.
//
// Ports
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   address[2:0]   word address
//   read, write    single-cycle access strobes
//   writedata[31:0], byteenable[3:0]  write data and byte lanes
//   readdata[31:0] registered read data, held between reads
//   readdatavalid  one-cycle pulse, one cycle after read
module led_nios_sysid_ext #(
    parameter logic [31:0] SYSTEM_ID   = 32'h5F178F7B,
    parameter logic [31:0] TIMESTAMP   = 32'h00000000,
    parameter logic [31:0] USER_WORD   = 32'h00000000,
    parameter int unsigned UPTIME_W    = 48,
    parameter logic [31:0] SCRATCH_RST = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    typedef enum logic [2:0] {
        REG_ID        = 3'd0,
        REG_TIMESTAMP = 3'd1,
        REG_USER      = 3'd2,
        REG_SCRATCH   = 3'd3,
        REG_UPTIME_LO = 3'd4,
        REG_UPTIME_HI = 3'd5,
        REG_STATUS    = 3'd6,
        REG_RESERVED  = 3'd7
    } reg_addr_t;

    localparam logic [7:0] WIDTH_CODE = 8'(UPTIME_W);

    reg_addr_t           reg_sel;
    logic [UPTIME_W-1:0] uptime;
    logic [63:0]         uptime_ext;
    logic [31:0]         hi_snap;
    logic [31:0]         scratch;
    logic [31:0]         scratch_next;
    logic [31:0]         read_mux;
    logic                wrap;
    logic                wrap_next;
    logic                rollover;

    assign reg_sel    = reg_addr_t'(address);
    assign uptime_ext = 64'(uptime);
    assign rollover   = (uptime == '1);

    always_comb begin
        read_mux = '0;
        case (reg_sel)
            REG_ID:        read_mux = SYSTEM_ID;
            REG_TIMESTAMP: read_mux = TIMESTAMP;
            REG_USER:      read_mux = USER_WORD;
            REG_SCRATCH:   read_mux = scratch;
            REG_UPTIME_LO: read_mux = uptime_ext[31:0];
            REG_UPTIME_HI: read_mux = hi_snap;
            REG_STATUS:    read_mux = {16'h0000, WIDTH_CODE, 7'b0000000, wrap};
            default:       read_mux = '0;
        endcase
    end

    always_comb begin
        scratch_next = scratch;
        if (write && reg_sel == REG_SCRATCH) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    scratch_next[8*i +: 8] = writedata[8*i +: 8];
                end
            end
        end
    end

    // Rollover set is applied after the W1C clear so a coincident set wins.
    always_comb begin
        wrap_next = wrap;
        if (write && reg_sel == REG_STATUS && writedata[0]) begin
            wrap_next = 1'b0;
        end
        if (rollover) begin
            wrap_next = 1'b1;
        end
    end

    // A LO read latches the upper counter bits from the same pre-increment
    // value it returns, so the LO/HI pair stays consistent across rollover.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime        <= '0;
            wrap          <= 1'b0;
            hi_snap       <= '0;
            scratch       <= SCRATCH_RST;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            uptime        <= uptime + 1'b1;
            wrap          <= wrap_next;
            scratch       <= scratch_next;
            readdatavalid <= read;
            if (read) begin
                readdata <= read_mux;
                if (reg_sel == REG_UPTIME_LO) begin
                    hi_snap <= uptime_ext[63:32];
                end
            end
        end
    end

endmodule

// File: doc/led_nios_sysid_ext.md
# led_nios_sysid_ext

Parametrised system-identification and uptime slave on the Nios II Avalon-MM data bus. It returns a fixed system ID, a build timestamp and a user build word. It also provides a byte-writable scratch register and a free-running uptime counter with coherent 64-bit readout and a sticky wrap flag. Software uses it to confirm the hardware image matches the compiled BSP and to timestamp events without a timer peripheral.

## Interface
Parameters:
- SYSTEM_ID, 32'h5F178F7B: value returned at word 0.
- TIMESTAMP, 32'h00000000: build time in Unix seconds, returned at word 1.
- USER_WORD, 32'h00000000: free build-info word, returned at word 2.
- UPTIME_W, 48: uptime counter width. Legal range 33..64.
- SCRATCH_RST, 32'h00000000: scratch register reset value.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- read  in  1  read strobe, one cycle per access.
- write  in  1  write strobe, one cycle per access.
- writedata  in  32  write data.
- byteenable  in  4  write byte lanes. Bit n enables writedata[8n+7:8n].
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for one cycle, one cycle after read.

## Operation
- Register map:
  - 0 ID (RO).
  - 1 TIMESTAMP (RO).
  - 2 USER_WORD (RO).
  - 3 SCRATCH (RW, byte-enabled).
  - 4 UPTIME_LO (RO).
  - 5 UPTIME_HI_SNAP (RO).
  - 6 STATUS: bit0 WRAP (sticky, W1C); bits[7:1] read 0; bits[15:8] = UPTIME_W; bits[31:16] read 0.
  - 7 reserved, reads 0.
- Uptime counter:
  - Increments by 1 every clock, modulo 2^UPTIME_W.
  - Rolling from all-ones to 0 sets WRAP.
- Coherent 64-bit readout:
  - A read of word 4 returns counter bits [31:0].
  - The same read latches counter bits [UPTIME_W-1:32], zero-extended to 32 bits, into the HI snapshot.
  - A read of word 5 returns the snapshot. The snapshot changes only on a word-4 read.
  - Software reads LO first, then HI.
- Writes:
  - Writes to word 3 update only the enabled byte lanes.
  - Writes to word 6 clear WRAP where writedata[0]=1.
  - Writes to all other words are ignored, with no side effect.
- read and write asserted together to the same address:
  - The read returns the pre-write value.
  - The write takes effect at the same edge.
- WRAP set and W1C clear in the same cycle: set wins and WRAP stays 1.
- Word-4 read in the same cycle as the counter rolls over:
  - LO and the snapshot both sample the pre-increment value.
  - The returned 64-bit pair is therefore consistent.

## Timing
- Reset values:
  - readdata = 0, readdatavalid = 0.
  - Counter = 0, WRAP = 0.
  - Snapshot = 0, SCRATCH = SCRATCH_RST.
- Read latency is fixed at 1:
  - A read sampled at edge N drives readdata and readdatavalid=1 from edge N until edge N+1.
  - readdata holds its value when no read is in progress.
- Counter value captured by a read at edge N equals N (cycles since reset release), modulo 2^UPTIME_W.
- Back-to-back reads on consecutive cycles are supported with no wait states. There is no waitrequest.
- Writes complete at the sampling edge. There is no write response.
- Asynchronous reset asserted mid-operation:
  - All state returns to reset values immediately.
  - An in-flight readdatavalid is dropped.
  - The counter restarts from 0 on the first edge after reset_n deasserts.

## Test plan
- Reset, then read words 0, 1, 2, 7 back-to-back -> readdatavalid high on 4 consecutive cycles, with data 0x5F178F7B, TIMESTAMP, USER_WORD, 0. No write to words 0-2 changes these values.
- Write 0xAABBCCDD to word 3 with byteenable=4'b1111, then write 0x11223344 with byteenable=4'b0101 -> word 3 reads 0xAA22CC44. Asserting reset restores SCRATCH_RST.
- Read word 4 at cycle 100 after reset release -> readdata=100. A following word-5 read returns 0.
- Run with UPTIME_W=33 until the counter passes 0x1_0000_0005, read word 4, wait 10 cycles, read word 5 -> LO=0x00000005 or later and HI=0x00000001, with HI taken from the LO-read instant.
- Run with UPTIME_W=33 through rollover -> WRAP=1 and STATUS=0x00002101. Writing 0x1 to word 6 clears WRAP. A W1C on the exact rollover cycle leaves WRAP=1.
- Assert reset_n low mid-read (read at edge N, reset before edge N+1) -> readdatavalid=0 and readdata=0 immediately. After release, the counter starts from 0.
